// File: rtl/sa_pkg.sv
// Shared types, default geometry and helpers for the systolic-array tile sequencer.
`ifndef SA_PKG_SV
`define SA_PKG_SV

// Lane j of a packed multi-lane bus whose lanes are w bits wide.
`define SA_LANE(j, w) [(j)*(w) +: (w)]

package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        START,
        DRAIN
    } sa_state_e;

    localparam int SA_ARRAY_W       = 8;
    localparam int SA_ARRAY_H       = 8;
    localparam int SA_X_W           = 8;
    localparam int SA_W_W           = 8;
    localparam int SA_MAC_W         = 19;
    localparam int SA_RBUF_DEPTH    = 8;
    localparam int SA_DRAIN_TIMEOUT = 256;

    localparam int SA_W_ADDR_W    = $clog2(SA_ARRAY_W * SA_ARRAY_H);
    localparam int SA_RBUF_ADDR_W = $clog2(SA_ARRAY_H) + $clog2(SA_RBUF_DEPTH);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`endif

// File: rtl/sa_result_deskew.sv
// Realigns skewed per-lane accumulator beats into whole result rows and
// presents completed rows in order on a valid/ready stream.
module sa_result_deskew
    import sa_pkg::*;
#(
    parameter int LANES = SA_ARRAY_W,
    parameter int MAC_W = SA_MAC_W,
    parameter int DEPTH = SA_RBUF_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic [LANES-1:0]       lane_v_i,
    input  logic [LANES*MAC_W-1:0] lane_data_i,
    output logic [LANES*MAC_W-1:0] res_data_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic                   all_done_o
);

    localparam int RA_W  = $clog2(DEPTH);
    localparam int PTR_W = RA_W + 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    logic [PTR_W-1:0]       wr_ptr_q [LANES];
    logic [PTR_W-1:0]       wr_ptr_d [LANES];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LANES-1:0]       lane_we;
    logic [LANES*MAC_W-1:0] row_mem  [DEPTH];

    // A row is complete once every lane's write pointer has moved past it.
    always_comb begin
        res_valid_o = 1'b1;
        all_done_o  = 1'b1;
        for (int j = 0; j < LANES; j++) begin
            lane_we[j]  = lane_v_i[j] && (wr_ptr_q[j] != PTR_FULL);
            wr_ptr_d[j] = clear_i ? '0 : wr_ptr_q[j] + PTR_W'(lane_we[j]);
            if (wr_ptr_q[j] <= rd_ptr_q) res_valid_o = 1'b0;
            if (wr_ptr_q[j] != PTR_FULL) all_done_o  = 1'b0;
        end
        rd_ptr_d   = clear_i ? '0 : rd_ptr_q + PTR_W'(res_valid_o && res_ready_i);
        res_data_o = res_valid_o ? row_mem[rd_ptr_q[RA_W-1:0]] : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            for (int j = 0; j < LANES; j++) wr_ptr_q[j] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            for (int j = 0; j < LANES; j++) wr_ptr_q[j] <= wr_ptr_d[j];
        end
    end

    // NOTE: the row storage has no reset; a row is never read until every lane has written it.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < LANES; j++) begin
            if (lane_we[j]) begin
                row_mem[wr_ptr_q[j][RA_W-1:0]] `SA_LANE(j, MAC_W) <= lane_data_i `SA_LANE(j, MAC_W);
            end
        end
    end

endmodule

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer: streams weights and activations into the pe_array buffers, fires
// start, then deskews the bottom-row accumulators into aligned result rows.
module sa_tile_sequencer
    import sa_pkg::*;
#(
    parameter int ARRAY_W       = SA_ARRAY_W,
    parameter int ARRAY_H       = SA_ARRAY_H,
    parameter int X_W           = SA_X_W,
    parameter int W_W           = SA_W_W,
    parameter int MAC_W         = SA_MAC_W,
    parameter int RBUF_DEPTH    = SA_RBUF_DEPTH,
    parameter int DRAIN_TIMEOUT = SA_DRAIN_TIMEOUT,
    localparam int IN_W = max_int(W_W, X_W),
    localparam int WA_W = $clog2(ARRAY_W * ARRAY_H),
    localparam int RA_W = $clog2(ARRAY_H) + $clog2(RBUF_DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_reload_i,
    input  logic [IN_W-1:0]          in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [W_W-1:0]           w_o,
    output logic [WA_W-1:0]          w_addr_o,
    output logic                     w_en_o,
    output logic [RA_W-1:0]          rbuf_waddr_o,
    output logic [X_W-1:0]           rbuf_wdata_o,
    output logic                     rbuf_w_vo,
    output logic                     start_vo,
    input  logic [ARRAY_W*MAC_W-1:0] mac_i,
    input  logic [ARRAY_W-1:0]       mac_v_i,
    output logic [ARRAY_W*MAC_W-1:0] res_data_o,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic                     busy_o,
    output logic                     err_timeout_o
);

    localparam int CNT_W = max_int(WA_W, RA_W);
    localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(ARRAY_W * ARRAY_H - 1);
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(ARRAY_H * RBUF_DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

    sa_state_e         state_q, state_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [W_W-1:0]    w_q, w_d;
    logic [WA_W-1:0]   w_addr_q, w_addr_d;
    logic              w_en_q, w_en_d;
    logic [X_W-1:0]    rbuf_wdata_q, rbuf_wdata_d;
    logic [RA_W-1:0]   rbuf_waddr_q, rbuf_waddr_d;
    logic              rbuf_w_q, rbuf_w_d;
    logic              start_q, start_d;

    logic              cmd_hs, in_hs, w_hs, x_hs;
    logic              in_drain, mac_any, timeout;
    logic              res_valid, all_done;
    logic [ARRAY_W-1:0] lane_v;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_hs) state_d = cmd_reload_i ? LOAD_W : LOAD_X;
            LOAD_W:  if (w_hs && beat_q == W_LAST) state_d = LOAD_X;
            LOAD_X:  if (x_hs && beat_q == X_LAST) state_d = START;
            START:   state_d = DRAIN;
            DRAIN:   if (all_done || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A new tile is only accepted once the previous tile's results have all been taken.
    always_comb begin
        cmd_ready_o = (state_q == IDLE) && !res_valid;
        in_ready_o  = (state_q == LOAD_W) || (state_q == LOAD_X);
        busy_o      = (state_q != IDLE);
        in_drain    = (state_q == DRAIN);
        cmd_hs      = cmd_valid_i && cmd_ready_o;
        in_hs       = in_valid_i && in_ready_o;
        w_hs        = in_hs && (state_q == LOAD_W);
        x_hs        = in_hs && (state_q == LOAD_X);
        lane_v      = in_drain ? mac_v_i : '0;
        mac_any     = |mac_v_i;
        timeout     = in_drain && !all_done && !mac_any && (tmo_q == TMO_LAST);
    end

    always_comb begin
        beat_d = beat_q;
        if (cmd_hs)    beat_d = '0;
        else if (w_hs) beat_d = (beat_q == W_LAST) ? '0 : beat_q + 1'b1;
        else if (x_hs) beat_d = (beat_q == X_LAST) ? '0 : beat_q + 1'b1;

        tmo_d        = (in_drain && !mac_any) ? tmo_q + 1'b1 : '0;
        err_d        = err_q || timeout;

        w_en_d       = w_hs;
        w_d          = w_hs ? in_data_i[W_W-1:0] : w_q;
        w_addr_d     = w_hs ? beat_q[WA_W-1:0]   : w_addr_q;
        rbuf_w_d     = x_hs;
        rbuf_wdata_d = x_hs ? in_data_i[X_W-1:0] : rbuf_wdata_q;
        rbuf_waddr_d = x_hs ? beat_q[RA_W-1:0]   : rbuf_waddr_q;
        start_d      = (state_q == START);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q       <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            w_q          <= '0;
            w_addr_q     <= '0;
            w_en_q       <= 1'b0;
            rbuf_wdata_q <= '0;
            rbuf_waddr_q <= '0;
            rbuf_w_q     <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            w_q          <= w_d;
            w_addr_q     <= w_addr_d;
            w_en_q       <= w_en_d;
            rbuf_wdata_q <= rbuf_wdata_d;
            rbuf_waddr_q <= rbuf_waddr_d;
            rbuf_w_q     <= rbuf_w_d;
            start_q      <= start_d;
        end
    end

    assign w_o           = w_q;
    assign w_addr_o      = w_addr_q;
    assign w_en_o        = w_en_q;
    assign rbuf_wdata_o  = rbuf_wdata_q;
    assign rbuf_waddr_o  = rbuf_waddr_q;
    assign rbuf_w_vo     = rbuf_w_q;
    assign start_vo      = start_q;
    assign err_timeout_o = err_q;
    assign res_valid_o   = res_valid;

    sa_result_deskew #(
        .LANES (ARRAY_W),
        .MAC_W (MAC_W),
        .DEPTH (RBUF_DEPTH)
    ) u_deskew (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (cmd_hs),
        .lane_v_i    (lane_v),
        .lane_data_i (mac_i),
        .res_data_o  (res_data_o),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready_i),
        .all_done_o  (all_done)
    );

endmodule
